ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to a keyboard over the shared open-drain PS/2 clock/data lines and checks the device acknowledge. It sits beside the PS/2 keyboard receiver on the same pins. While a transfer is in progress it asserts busy so the receiver ignores line activity.

---
 rtl/ps2_host_tx.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, clocks one byte out on
// device-generated falling edges, checks the device acknowledge.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int SETUP_CYCLES   = 250,
  parameter int START_TIMEOUT  = 750000,
  parameter int BIT_TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int MAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int MAX_B = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] LD_INH   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_SET   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_START = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_BIT   = CNT_W'(BIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_cnt_zero;
  logic [9:0]       r_shift;
  logic [3:0]       r_bit_cnt;
  logic             r_ack_bad;
  logic             r_clk_oe;
  logic             r_data_oe;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic             w_finish;
  logic [1:0]       w_code;
  logic             w_fe;

  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_data_s1, r_data_s2;

  // Pin synchronizers; idle-high lines so they reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_data_s1  <= ps2_data_in;
      r_data_s2  <= r_data_s1;
    end
  end

  assign w_fe       = r_clk_prev & ~r_clk_s2;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_dec  = r_cnt - CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_finish     = 1'b0;
    w_code       = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_next_state = S_INHIBIT;
          w_cnt_next   = LD_INH;
        end
      end
      S_INHIBIT: begin
        if (w_cnt_zero) begin
          w_next_state = S_RTS;
          w_cnt_next   = LD_SET;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end
      S_RTS: begin
        if (w_cnt_zero) begin
          w_next_state = S_SEND;
          w_cnt_next   = LD_START;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end
      // A falling edge in the expiry cycle wins over the timeout.
      S_SEND: begin
        if (w_fe) begin
          w_cnt_next = LD_BIT;
          if (r_bit_cnt == 4'd9) w_next_state = S_ACK;
        end else if (w_cnt_zero) begin
          w_next_state = S_IDLE;
          w_finish     = 1'b1;
          w_code       = 2'b10;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end
      S_ACK: begin
        if (w_fe) begin
          w_next_state = S_RELEASE;
          w_cnt_next   = LD_BIT;
        end else if (w_cnt_zero) begin
          w_next_state = S_IDLE;
          w_finish     = 1'b1;
          w_code       = 2'b10;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end
      S_RELEASE: begin
        if (r_clk_s2 && r_data_s2) begin
          w_next_state = S_IDLE;
          w_finish     = 1'b1;
          w_code       = r_ack_bad ? 2'b01 : 2'b00;
        end else if (w_cnt_zero) begin
          w_next_state = S_IDLE;
          w_finish     = 1'b1;
          w_code       = 2'b10;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Line drivers are registered from next state so the pins never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_ack_bad  <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      if (r_state == S_IDLE && tx_valid) begin
        r_shift   <= {1'b1, ~^tx_data, tx_data};
        r_bit_cnt <= '0;
        r_ack_bad <= 1'b0;
      end else if (r_state == S_SEND && w_fe) begin
        r_shift   <= {1'b0, r_shift[9:1]};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end

      if (r_state == S_ACK && w_fe) r_ack_bad <= r_data_s2;

      r_clk_oe <= (w_next_state == S_INHIBIT) || (w_next_state == S_RTS);

      if (w_next_state == S_RTS) begin
        r_data_oe <= 1'b1;
      end else if (w_next_state == S_SEND) begin
        if (r_state == S_SEND && w_fe) r_data_oe <= ~r_shift[0];
      end else begin
        r_data_oe <= 1'b0;
      end

      r_done <= w_finish;
      r_err  <= w_finish && (w_code != 2'b00);
      if (w_finish) r_err_code <= w_code;
    end
  end

  assign tx_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign done        = r_done;
  assign err         = r_err;
  assign err_code    = r_err_code;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: table of bytes sent to a wired-AND keyboard model,
// plus directed timeout, reset and back-to-back request sequences.
module tb_ps2_host_tx;

  localparam int INH = 60;
  localparam int SET = 10;
  localparam int STO = 300;
  localparam int BTO = 100;
  localparam int H   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic [1:0] err_code;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  // Open-drain lines: host pulls low via oe, device pulls low via dev_*.
  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .START_TIMEOUT (STO),
    .BIT_TIMEOUT   (BTO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_acc = 0;
  int n_inh = 0;
  int n_rts = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) begin
    cyc++;
    if (tx_valid && tx_ready && !rst) n_acc++;
  end

  always @(negedge clk) begin
    if (ps2_clk_oe && !ps2_data_oe) n_inh++;
    if (ps2_clk_oe && ps2_data_oe)  n_rts++;
  end

  typedef struct {
    logic [7:0]  data;
    logic        ack;
    logic [10:0] bits;
    logic        err;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[5];

  logic        d_found, d_err, d_clk_oe, d_data_oe, d_ready;
  logic [1:0]  d_code;
  int          t_done;
  logic [10:0] got_bits, got_bits2;
  int          t_ev;
  logic        dev_ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(posedge clk); #1;
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  // Keyboard model: waits for clock release, then generates nfalls clock
  // pulses. bits[0] is the start bit, bits[i] sampled on rising edge i.
  // t_out is the cycle of the last falling edge (or of release if nfalls=0).
  task automatic device(input int nfalls, input logic ack, output logic [10:0] bits,
                        output int t_out, output logic ok);
    ok    = 1'b0;
    bits  = '0;
    t_out = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (busy && !ps2_clk_oe) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    t_out = cyc;
    if (nfalls == 0) return;
    repeat (H) @(posedge clk);
    #1;
    bits[0] = ps2_data_in;
    for (int i = 1; i <= nfalls; i++) begin
      if (i == 11 && ack) dev_data = 1'b0;
      repeat (H) @(posedge clk);
      #1;
      dev_clk = 1'b0;
      t_out   = cyc;
      repeat (H) @(posedge clk);
      #1;
      dev_clk = 1'b1;
      if (i <= 10) bits[i] = ps2_data_in;
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    d_found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (done) begin
        d_found   = 1'b1;
        d_err     = err;
        d_code    = err_code;
        d_clk_oe  = ps2_clk_oe;
        d_data_oe = ps2_data_oe;
        d_ready   = tx_ready;
        t_done    = cyc;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    vecs[0] = '{8'hED, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b0, 2'b00};
    vecs[1] = '{8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b0, 2'b00};
    vecs[2] = '{8'h00, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b0, 2'b00};
    vecs[3] = '{8'h01, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0}, 1'b0, 2'b00};
    vecs[4] = '{8'hF0, 1'b0, {1'b1, 1'b1, 8'hF0, 1'b0}, 1'b1, 2'b01};

    repeat (3) @(posedge clk);
    #1;
    check("reset tx_ready", tx_ready, 1);
    check("reset clk_oe", ps2_clk_oe, 0);
    check("reset data_oe", ps2_data_oe, 0);
    check("reset busy", busy, 0);
    check("reset done/err/code", {done, err, err_code}, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      n_inh = 0;
      n_rts = 0;
      acc0  = n_acc;
      send_byte(vecs[i].data);
      fork
        device(11, vecs[i].ack, got_bits, t_ev, dev_ok);
        wait_done(3000);
        begin
          repeat (20) @(posedge clk);
          #1 tx_valid = 1'b1;
          @(posedge clk);
          #1 tx_valid = 1'b0;
          repeat (10) @(posedge clk);
          #1 tx_valid = 1'b1;
          @(posedge clk);
          #1 tx_valid = 1'b0;
        end
      join
      check($sformatf("vec%0d release seen", i), dev_ok, 1);
      check($sformatf("vec%0d line bits", i), got_bits, vecs[i].bits);
      check($sformatf("vec%0d done", i), d_found, 1);
      check($sformatf("vec%0d err", i), d_err, vecs[i].err);
      check($sformatf("vec%0d err_code", i), d_code, vecs[i].code);
      check($sformatf("vec%0d oe at done", i), {d_clk_oe, d_data_oe}, 0);
      check($sformatf("vec%0d ready at done", i), d_ready, 1);
      check($sformatf("vec%0d inhibit cycles", i), n_inh, INH);
      check($sformatf("vec%0d setup cycles", i), n_rts, SET);
      check($sformatf("vec%0d accepts", i), n_acc - acc0, 1);
      @(posedge clk); #1;
      check($sformatf("vec%0d done one cycle", i), done, 0);
      check($sformatf("vec%0d code held", i), err_code, vecs[i].code);
    end

    // Device never clocks.
    send_byte(8'hAA);
    device(0, 1'b0, got_bits, t_ev, dev_ok);
    wait_done(STO + 50);
    check("start_to done", d_found, 1);
    check("start_to latency", t_done - t_ev, STO);
    check("start_to err/code", {d_err, d_code}, 3'b110);
    check("start_to oe", {d_clk_oe, d_data_oe}, 0);

    // Device stops after four falling edges.
    send_byte(8'h3C);
    device(4, 1'b0, got_bits, t_ev, dev_ok);
    wait_done(BTO + 50);
    check("bit_to done", d_found, 1);
    check("bit_to latency", t_done - t_ev, BTO + 3);
    check("bit_to err/code", {d_err, d_code}, 3'b110);
    check("bit_to oe", {d_clk_oe, d_data_oe}, 0);

    // Asynchronous reset in the middle of SEND.
    send_byte(8'hA5);
    device(3, 1'b0, got_bits, t_ev, dev_ok);
    @(negedge clk);
    check("mid-send busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rst oe released", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst tx_ready", tx_ready, 1);
    check("rst code cleared", err_code, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // tx_valid held: the second byte is taken in the done cycle.
    acc0 = n_acc;
    @(posedge clk); #1;
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h02;
    fork
      device(11, 1'b1, got_bits, t_ev, dev_ok);
      wait_done(3000);
    join
    check("held first done", d_found, 1);
    check("held first bits", got_bits, {1'b1, 1'b0, 8'h01, 1'b0});
    check("held ready in done", d_ready, 1);
    @(posedge clk); #1;
    check("held second accepted", busy, 1);
    tx_valid = 1'b0;
    fork
      device(11, 1'b1, got_bits2, t_ev, dev_ok);
      wait_done(3000);
    join
    check("held second bits", got_bits2, {1'b1, 1'b0, 8'h02, 1'b0});
    check("held second code", {d_found, d_err, d_code}, 4'b1000);
    check("held accepts", n_acc - acc0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
